// File: rtl/pc_gen_unit.sv
// Fetch-stage program counter generator: sequential, branch, jump-register,
// exception entry/return, with a BOOT/RUN/EXC state machine and EPC capture.
module pc_gen_unit #(
    parameter int                 PC_SIZE      = 32,
    parameter int                 SEL_SIZE     = 3,
    parameter logic [PC_SIZE-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [PC_SIZE-1:0] EXC_VECTOR   = 32'h0000_0008,
    parameter int                 PC_INC       = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [SEL_SIZE-1:0] i_pc_select,
    input  logic [PC_SIZE-1:0]  i_imm,
    input  logic [PC_SIZE-1:0]  i_jr_target,
    input  logic                i_stall,
    input  logic                i_fetch_ready,
    output logic [PC_SIZE-1:0]  o_pc,
    output logic                o_fetch_valid,
    output logic [PC_SIZE-1:0]  o_epc,
    output logic                o_in_exception,
    output logic                o_sel_err
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_EXC  = 2'd2
    } state_t;

    localparam logic [SEL_SIZE-1:0] SEL_ADD4   = SEL_SIZE'(0);
    localparam logic [SEL_SIZE-1:0] SEL_BRANCH = SEL_SIZE'(1);
    localparam logic [SEL_SIZE-1:0] SEL_EXC    = SEL_SIZE'(2);
    localparam logic [SEL_SIZE-1:0] SEL_JR     = SEL_SIZE'(3);
    localparam logic [SEL_SIZE-1:0] SEL_ERET   = SEL_SIZE'(4);

    state_t              r_state;
    logic                w_adv;
    logic                w_illegal;
    logic                w_excEntry;
    logic [PC_SIZE-1:0]  w_seqPc;
    logic [PC_SIZE-1:0]  w_branchPc;
    logic [PC_SIZE-1:0]  w_jrPc;

    // Candidate targets; all sums wrap modulo 2^PC_SIZE.
    always_comb begin
        w_seqPc    = o_pc + PC_SIZE'(PC_INC);
        w_branchPc = o_pc + (i_imm << 1);
        w_jrPc     = {i_jr_target[PC_SIZE-1:1], 1'b0};
        w_adv      = o_fetch_valid & i_fetch_ready & ~i_stall;
        w_illegal  = 1'b0;
        w_excEntry = 1'b0;
        if (r_state != ST_BOOT) begin
            w_illegal  = (i_pc_select > SEL_ERET) ||
                         ((i_pc_select == SEL_ERET) && (r_state == ST_RUN));
            w_excEntry = (i_pc_select == SEL_EXC) && (r_state == ST_RUN);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_BOOT;
            o_pc           <= RESET_VECTOR;
            o_epc          <= '0;
            o_fetch_valid  <= 1'b0;
            o_in_exception <= 1'b0;
            o_sel_err      <= 1'b0;
        end else begin
            o_sel_err <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_state       <= ST_RUN;
                    o_fetch_valid <= 1'b1;
                end
                default: begin
                    o_sel_err <= w_illegal;
                    // Exception entry ignores stall and fetch handshake.
                    if (w_excEntry) begin
                        o_epc          <= o_pc;
                        o_pc           <= EXC_VECTOR;
                        o_in_exception <= 1'b1;
                        r_state        <= ST_EXC;
                    end else if (!w_illegal && w_adv) begin
                        case (i_pc_select)
                            SEL_BRANCH: o_pc <= w_branchPc;
                            SEL_JR:     o_pc <= w_jrPc;
                            SEL_ERET: begin
                                o_pc           <= o_epc;
                                o_in_exception <= 1'b0;
                                r_state        <= ST_RUN;
                            end
                            default:    o_pc <= w_seqPc;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] jrTarget;
    logic        stall;
    logic        ready;
    logic [31:0] oPc;
    logic        oValid;
    logic [31:0] oEpc;
    logic        oExc;
    logic        oErr;

    int checks = 0;
    int errors = 0;
    bit cmpEn  = 1'b0;

    logic [31:0] mPc   = 32'h0;
    logic [31:0] mEpc  = 32'h0;
    logic        mValid = 1'b0;
    logic        mExc  = 1'b0;
    logic        mErr  = 1'b0;
    logic        mBoot = 1'b1;
    logic        mAdv;

    pc_gen_unit dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_pc_select    (sel),
        .i_imm          (imm),
        .i_jr_target    (jrTarget),
        .i_stall        (stall),
        .i_fetch_ready  (ready),
        .o_pc           (oPc),
        .o_fetch_valid  (oValid),
        .o_epc          (oEpc),
        .o_in_exception (oExc),
        .o_sel_err      (oErr)
    );

    always #5 clk = ~clk;

    // Reference behaviour: what the PC unit must hold after each edge.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mPc    = 32'h0;
            mEpc   = 32'h0;
            mValid = 1'b0;
            mExc   = 1'b0;
            mErr   = 1'b0;
            mBoot  = 1'b1;
        end else if (mBoot) begin
            mBoot  = 1'b0;
            mValid = 1'b1;
            mErr   = 1'b0;
        end else begin
            mAdv = mValid && ready && !stall;
            mErr = (sel >= 3'd5) || (sel == 3'd4 && !mExc);
            if (!mErr) begin
                if (sel == 3'd2 && !mExc) begin
                    mEpc = mPc;
                    mPc  = 32'h8;
                    mExc = 1'b1;
                end else if (mAdv) begin
                    case (sel)
                        3'd1: mPc = mPc + imm * 32'd2;
                        3'd3: mPc = jrTarget & ~32'h1;
                        3'd4: begin
                            mPc  = mEpc;
                            mExc = 1'b0;
                        end
                        default: mPc = mPc + 32'd4;
                    endcase
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Sets inputs at a falling edge and returns at the next falling edge.
    task automatic applyStimulus(input logic [2:0] s, input logic [31:0] i,
                                 input logic [31:0] j, input logic st, input logic rd);
        sel      = s;
        imm      = i;
        jrTarget = j;
        stall    = st;
        ready    = rd;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("model_pc", oPc, mPc);
            checkOutput("model_epc", oEpc, mEpc);
            checkOutput("model_valid", {31'h0, oValid}, {31'h0, mValid});
            checkOutput("model_exc", {31'h0, oExc}, {31'h0, mExc});
            checkOutput("model_err", {31'h0, oErr}, {31'h0, mErr});
        end
    end

    initial begin
        rstN = 1'b0;
        sel = 3'd0; imm = 32'h0; jrTarget = 32'h0; stall = 1'b0; ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_pc", oPc, 32'h0);
        checkOutput("rst_valid", {31'h0, oValid}, 32'h0);
        checkOutput("rst_epc", oEpc, 32'h0);
        checkOutput("rst_exc", {31'h0, oExc}, 32'h0);
        cmpEn = 1'b1;
        rstN  = 1'b1;

        applyStimulus(3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("boot_pc", oPc, 32'h0);
        checkOutput("boot_valid", {31'h0, oValid}, 32'h1);
        applyStimulus(3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("seq_4", oPc, 32'h4);
        applyStimulus(3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        applyStimulus(3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("seq_12", oPc, 32'hC);

        applyStimulus(3'd3, 32'h0, 32'h100, 1'b0, 1'b1);
        applyStimulus(3'd1, 32'hFFFF_FFF8, 32'h0, 1'b0, 1'b1);
        checkOutput("branch_back", oPc, 32'hF0);
        applyStimulus(3'd3, 32'h0, 32'h100, 1'b0, 1'b1);
        applyStimulus(3'd1, 32'hFFFF_FFF8, 32'h0, 1'b1, 1'b1);
        checkOutput("branch_stall", oPc, 32'h100);

        applyStimulus(3'd3, 32'h0, 32'h200, 1'b0, 1'b1);
        applyStimulus(3'd2, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("exc_pc", oPc, 32'h8);
        checkOutput("exc_epc", oEpc, 32'h200);
        checkOutput("exc_flag", {31'h0, oExc}, 32'h1);
        applyStimulus(3'd2, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("nested_pc", oPc, 32'hC);
        checkOutput("nested_epc", oEpc, 32'h200);
        applyStimulus(3'd4, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("eret_pc", oPc, 32'h200);
        checkOutput("eret_flag", {31'h0, oExc}, 32'h0);
        applyStimulus(3'd4, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("eret_run_err", {31'h0, oErr}, 32'h1);
        checkOutput("eret_run_pc", oPc, 32'h200);
        applyStimulus(3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("err_one_cycle", {31'h0, oErr}, 32'h0);
        checkOutput("after_err_pc", oPc, 32'h204);

        applyStimulus(3'd3, 32'h0, 32'h1235, 1'b0, 1'b1);
        checkOutput("jr_pc", oPc, 32'h1234);
        applyStimulus(3'd7, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("rsvd_err", {31'h0, oErr}, 32'h1);
        checkOutput("rsvd_pc", oPc, 32'h1234);

        applyStimulus(3'd3, 32'h0, 32'hFFFF_FFFD, 1'b0, 1'b1);
        checkOutput("near_top", oPc, 32'hFFFF_FFFC);
        applyStimulus(3'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("wrap_pc", oPc, 32'h0);
        checkOutput("wrap_err", {31'h0, oErr}, 32'h0);

        applyStimulus(3'd2, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("exc2_flag", {31'h0, oExc}, 32'h1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("async_pc", oPc, 32'h0);
        checkOutput("async_epc", oEpc, 32'h0);
        checkOutput("async_exc", {31'h0, oExc}, 32'h0);
        checkOutput("async_valid", {31'h0, oValid}, 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        for (int n = 0; n < 3000; n++) begin
            logic [3:0]  pick;
            logic [2:0]  s;
            pick = 4'($urandom_range(0, 9));
            s    = (pick > 4'd7) ? 3'd0 : pick[2:0];
            if ($urandom_range(0, 299) == 0) begin
                #2 rstN = 1'b0;
                #1 rstN = 1'b1;
            end
            applyStimulus(s, $urandom, $urandom,
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
        end

        cmpEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
